// File: rtl/neuron_layer_ctrl.sv
// Sequencer for one layer of fixed-latency neurons sharing a single input
// vector. It accepts a vector, pulses Run once, waits the neuron latency,
// captures all Y outputs and offers them downstream. Frames are never
// overlapped.
module neuron_layer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int N_IN       = 4,
  parameter int N_OUT      = 3,
  parameter int NEURON_LAT = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_IN*DATA_WIDTH-1:0]  in_data,
  output logic [N_IN*DATA_WIDTH-1:0]  x_out,
  output logic                        neuron_en,
  output logic                        neuron_run,
  output logic                        neuron_rst,
  input  logic [N_OUT*DATA_WIDTH-1:0] neuron_y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_OUT*DATA_WIDTH-1:0] out_data,
  output logic [15:0]                 frame_cnt
);

  // One extra bit keeps NEURON_LAT-1 representable for any latency value.
  localparam int CNT_W = $clog2(NEURON_LAT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   wait_cnt_reg;
  logic [CNT_W-1:0]   wait_cnt_next;
  logic               neuron_rst_reg;
  logic [15:0]        frame_cnt_reg;

  logic               load_x;
  logic               load_y;
  logic               count_frame;

  // State and wait counter; reset parks the controller in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Neuron reset is high during reset and for the single cycle after clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neuron_rst_reg <= 1'b1;
    end else begin
      neuron_rst_reg <= clr;
    end
  end

  // Next-state and Moore outputs; clr overrides every transition and strobe.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    neuron_run    = 1'b0;
    neuron_en     = 1'b0;
    load_x        = 1'b0;
    load_y        = 1'b0;
    count_frame   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Not ready while the neurons are still being cleared.
        in_ready = !neuron_rst_reg;
        if (in_valid && !neuron_rst_reg) begin
          load_x     = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        neuron_run    = 1'b1;
        neuron_en     = 1'b1;
        wait_cnt_next = CNT_W'(NEURON_LAT - 1);
        state_next    = S_WAIT;
      end
      S_WAIT: begin
        // En stays high: a neuron repeats its current step if En drops.
        neuron_en = 1'b1;
        if (wait_cnt_reg == '0) begin
          state_next = S_CAPTURE;
        end else begin
          wait_cnt_next = wait_cnt_reg - CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        neuron_en  = 1'b1;
        load_y     = 1'b1;
        state_next = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          count_frame = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort: no handshake completes in the clr cycle and nothing is loaded.
    if (clr) begin
      state_next  = S_IDLE;
      load_x      = 1'b0;
      load_y      = 1'b0;
      count_frame = 1'b0;
    end
  end

  // Per-lane input vector register; held from acceptance until the next one.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_x_lane
      logic [DATA_WIDTH-1:0] x_lane_reg;

      // Capture one input sample on acceptance.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          x_lane_reg <= '0;
        end else if (load_x) begin
          x_lane_reg <= in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      assign x_out[gi*DATA_WIDTH +: DATA_WIDTH] = x_lane_reg;
    end

    for (gi = 0; gi < N_OUT; gi++) begin : g_y_lane
      logic [DATA_WIDTH-1:0] y_lane_reg;

      // Capture one neuron output in CAPTURE; stable through HOLD.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          y_lane_reg <= '0;
        end else if (load_y) begin
          y_lane_reg <= neuron_y[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = y_lane_reg;
    end
  endgenerate

  // Completed output handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_reg <= '0;
    end else if (count_frame) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign neuron_rst = neuron_rst_reg;
  assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Scoreboard bench for neuron_layer_ctrl with a behavioural neuron layer.
module tb_neuron_layer_ctrl;

  localparam int DW  = 8;
  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] x_out;
  logic        neuron_en;
  logic        neuron_run;
  logic        neuron_rst;
  logic [23:0] neuron_y;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [15:0] frame_cnt;

  neuron_layer_ctrl #(
    .DATA_WIDTH(DW), .N_IN(4), .N_OUT(3), .NEURON_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .x_out(x_out), .neuron_en(neuron_en), .neuron_run(neuron_run),
    .neuron_rst(neuron_rst), .neuron_y(neuron_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors (X1 in LSBs) and hand-computed layer outputs (neuron 0 in LSBs).
  // n0 = relu(x1+x2+x3+x4 >>> 1), n1 = relu(2x1-x2+x4 >>> 1), n2 = relu(x2-x3+2x4 >>> 1), sat 127
  logic [31:0] vin  [5];
  logic [23:0] vexp [5];
  initial begin
    vin[0] = 32'h04FE0310; vexp[0] = 24'h06100A;  // {4,-2,3,16}
    vin[1] = 32'h01140AFB; vexp[1] = 24'h00000D;  // {1,20,10,-5}
    vin[2] = 32'h7F7F7F7F; vexp[2] = 24'h7F7F7F;  // saturation
    vin[3] = 32'h04030201; vexp[3] = 24'h030205;  // {4,3,2,1}
    vin[4] = 32'h3280FF00; vexp[4] = 24'h711900;  // {50,-128,-1,0}
  end

  // Behavioural neurons: LOAD..RESULT schedule, Y valid LAT edges after Run is sampled.
  function automatic logic [7:0] act(input int s);
    int t;
    t = s >>> 1;
    if (t < 0) t = 0;
    if (t > 127) t = 127;
    return 8'(t);
  endfunction

  function automatic logic [23:0] layer_f(input logic [31:0] xv);
    int x [4];
    for (int i = 0; i < 4; i++) x[i] = int'($signed(xv[8*i +: 8]));
    return {act(x[1] - x[2] + 2*x[3]), act(2*x[0] - x[1] + x[3]), act(x[0] + x[1] + x[2] + x[3])};
  endfunction

  logic [3:0]  ncnt;
  logic [31:0] nx;
  always @(posedge clk) begin
    if (neuron_rst) begin
      ncnt     <= '0;
      neuron_y <= '0;
    end else if (neuron_en) begin
      if (neuron_run) begin
        ncnt     <= 4'(LAT);
        nx       <= x_out;
        neuron_y <= 24'h555555;
      end else if (ncnt != 0) begin
        ncnt <= ncnt - 4'd1;
        if (ncnt == 4'd1) neuron_y <= layer_f(nx);
      end
    end
  end

  // Scoreboard state shared by driver and monitor.
  int          checks = 0;
  int          errors = 0;
  logic [23:0] sb [$];
  bit          active = 0;
  int          acc_cyc = 0;
  logic [31:0] cur_x = '0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] req_v);
    checks++;
    if (act_v !== req_v) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act_v, req_v, cyc);
    end
  endtask

  // Monitor: sampled on the falling edge, pops expectations on output handshakes.
  initial begin
    bit          prev_ov;
    logic [23:0] prev_data;
    int          d;
    logic [23:0] e;
    prev_ov = 0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("frame_cnt", frame_cnt, exp_cnt);
        if (active) begin
          d = cyc - acc_cyc;
          chk("run_pulse", neuron_run, d == 0);
          chk("neuron_en", neuron_en, d <= 7);
          chk("out_valid_timing", out_valid, d >= 8);
          chk("in_ready_busy", in_ready, 0);
          chk("x_out_stable", x_out, cur_x);
          if (out_valid && prev_ov) chk("out_data_stable", out_data, prev_data);
        end else begin
          chk("idle_out_valid", out_valid, 0);
          chk("idle_run", neuron_run, 0);
          chk("idle_en", neuron_en, 0);
        end
        if (out_valid && out_ready && !clr) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            $display("output frame: out_data=%06h expected=%06h", out_data, e);
            chk("out_data", out_data, e);
          end
          exp_cnt = exp_cnt + 16'd1;
          active  = 0;
        end
        prev_ov   = out_valid;
        prev_data = out_data;
      end else begin
        prev_ov = 0;
      end
    end
  end

  // Offer one vector; records acceptance and pushes the expected result.
  task automatic send(input int v, input bit keep_valid);
    bit got;
    got = 0;
    in_data  = vin[v];
    in_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cur_x   = vin[v];
    sb.push_back(vexp[v]);
    active  = 1;
    $display("input frame %0d accepted at cycle %0d: in_data=%08h", v, cyc, vin[v]);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (active && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (active) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset values and release behaviour.
    #22;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_neuron_rst", neuron_rst, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_run", neuron_run, 0);
    chk("rst_en", neuron_en, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    #5 rst = 1'b1;
    #2;
    chk("release_in_ready_pre", in_ready, 0);
    chk("release_neuron_rst_pre", neuron_rst, 1);
    @(posedge clk); #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_neuron_rst", neuron_rst, 0);

    // Asynchronous reset in the middle of WAIT.
    out_ready = 1'b1;
    send(0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    active = 0;
    sb.delete();
    exp_cnt = '0;
    #1;
    chk("midrst_x_out", x_out, 0);
    chk("midrst_en", neuron_en, 0);
    chk("midrst_run", neuron_run, 0);
    chk("midrst_neuron_rst", neuron_rst, 1);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_in_ready", in_ready, 1);
    chk("midrst_release_neuron_rst", neuron_rst, 0);

    // Single frame.
    send(0, 0);
    wait_idle();
    chk("single_frame_cnt", frame_cnt, 1);

    // Backpressure for 20 cycles with a competing input offered.
    out_ready = 1'b0;
    send(1, 0);
    wait_ov();
    in_data  = 32'hDEADBEEF;
    in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("backpressure_frame_cnt", frame_cnt, 2);

    // Back-to-back with in_valid held high.
    send(2, 1); a0 = acc_cyc;
    send(3, 1); a1 = acc_cyc;
    send(4, 0); a2 = acc_cyc;
    chk("b2b_spacing_1", a1 - a0, 10);
    chk("b2b_spacing_2", a2 - a1, 10);
    wait_idle();
    chk("b2b_frame_cnt", frame_cnt, 5);

    // Abort while the wait counter holds 3.
    send(3, 0);
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    active = 0;
    void'(sb.pop_back());
    chk("abort_neuron_rst", neuron_rst, 1);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_en", neuron_en, 0);
    chk("abort_x_out_kept", x_out, vin[3]);
    @(posedge clk); #1;
    chk("abort_neuron_rst_end", neuron_rst, 0);
    chk("abort_in_ready_end", in_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    send(4, 0);
    wait_idle();
    chk("abort_frame_cnt", frame_cnt, 6);

    // Counter wrap.
    force dut.frame_cnt_reg = 16'hFFFF;
    #1 release dut.frame_cnt_reg;
    exp_cnt = 16'hFFFF;
    #1;
    chk("preload_frame_cnt", frame_cnt, 16'hFFFF);
    send(3, 0);
    wait_idle();
    chk("wrap_frame_cnt", frame_cnt, 0);

    // clr coincident with an output handshake in HOLD.
    out_ready = 1'b0;
    send(0, 0);
    wait_ov();
    clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    out_ready = 1'b0;
    active = 0;
    void'(sb.pop_back());
    chk("collision_frame_cnt", frame_cnt, 0);
    chk("collision_out_valid", out_valid, 0);
    chk("collision_out_data_kept", out_data, vexp[0]);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2, 0);
    wait_idle();
    chk("final_frame_cnt", frame_cnt, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
